// File: rtl/imm_extend_if.sv
// imm_extend_if: start/busy/done handshake and result bus of the immediate extend unit
interface imm_extend_if;
    logic        Start;
    logic [23:0] Instr;
    logic [2:0]  ImmSrc;
    logic        Busy;
    logic        Done;
    logic [31:0] ExtImm;
    logic        ImmCarry;
    logic        ImmCarryValid;
    logic        IllegalSrc;
    modport master (output Start, Instr, ImmSrc,
                    input  Busy, Done, ExtImm, ImmCarry, ImmCarryValid, IllegalSrc);
    modport slave  (input  Start, Instr, ImmSrc,
                    output Busy, Done, ExtImm, ImmCarry, ImmCarryValid, IllegalSrc);
endinterface

// File: rtl/imm_extend_unit.sv
// imm_extend_unit: multi-cycle ARM immediate decode/extend with iterative or single-cycle rotate
module imm_extend_unit #(
    parameter int FAST_ROT     = 0,
    parameter int ILLEGAL_ZERO = 1
) (
    input logic         clk,
    input logic         reset,
    imm_extend_if.slave bus
);
    typedef enum logic [1:0] {IDLE, ROT, DONE} state_t;
    state_t      state_q;
    logic [31:0] shreg_q, ext_q, ror2_d, ror_full_d, res_d;
    logic [3:0]  cnt_q;
    logic        busy_q, done_q, carry_q, cv_q, ill_q;
    logic        accept_d, iter_d, legal_d, rotated_d;
    logic [5:0]  sh_d;
    logic [31:0] imm8_d;
    // Decode the live request; only used on the accepting edge, so later input changes are harmless
    always_comb begin
        imm8_d     = {24'b0, bus.Instr[7:0]};
        sh_d       = {1'b0, bus.Instr[11:8], 1'b0};
        ror_full_d = (imm8_d >> sh_d) | (imm8_d << (6'd32 - sh_d));
        ror2_d     = {shreg_q[1:0], shreg_q[31:2]};
        legal_d    = bus.ImmSrc <= 3'd4;
        rotated_d  = bus.ImmSrc == 3'd0 && bus.Instr[11:8] != 4'd0;
        iter_d     = rotated_d && FAST_ROT == 0;
        accept_d   = bus.Start && state_q != ROT;
        res_d      = bus.ImmSrc == 3'd0 ? ror_full_d :
                     bus.ImmSrc == 3'd1 ? {20'b0, bus.Instr[11:0]} :
                     bus.ImmSrc == 3'd2 ? {{6{bus.Instr[23]}}, bus.Instr, 2'b00} :
                     bus.ImmSrc == 3'd3 ? {24'b0, bus.Instr[11:8], bus.Instr[3:0]} :
                                          imm8_d;
    end
    // FSM with registered handshake and result; ROT shifts the captured operand 2 bits per edge
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
            shreg_q <= '0;
            cnt_q   <= '0;
            ext_q   <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            carry_q <= 1'b0;
            cv_q    <= 1'b0;
            ill_q   <= 1'b0;
        end else if (state_q == ROT) begin
            shreg_q <= ror2_d;
            cnt_q   <= cnt_q - 4'd1;
            if (cnt_q == 4'd1) begin
                state_q <= DONE;
                ext_q   <= ror2_d;
                carry_q <= ror2_d[31];
                cv_q    <= 1'b1;
                ill_q   <= 1'b0;
                busy_q  <= 1'b0;
                done_q  <= 1'b1;
            end
        end else if (accept_d && iter_d) begin
            state_q <= ROT;
            shreg_q <= imm8_d;
            cnt_q   <= bus.Instr[11:8];
            busy_q  <= 1'b1;
            done_q  <= 1'b0;
        end else if (accept_d) begin
            state_q <= DONE;
            ext_q   <= legal_d ? res_d : (ILLEGAL_ZERO != 0 ? 32'd0 : ext_q);
            carry_q <= rotated_d && res_d[31];
            cv_q    <= rotated_d;
            ill_q   <= !legal_d;
            done_q  <= 1'b1;
        end else begin
            state_q <= IDLE;
            done_q  <= 1'b0;
        end
    end
    assign bus.Busy          = busy_q;
    assign bus.Done          = done_q;
    assign bus.ExtImm        = ext_q;
    assign bus.ImmCarry      = carry_q;
    assign bus.ImmCarryValid = cv_q;
    assign bus.IllegalSrc    = ill_q;
endmodule

// File: tb/tb_imm_extend_unit.sv
// tb_imm_extend_unit: directed checks of iterative (u0) and fast-rotate, keep-on-illegal (u1) instances
module tb_imm_extend_unit;
    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        start = 1'b0;
    logic [23:0] instr = '0;
    logic [2:0]  src = '0;
    int          checks = 0;
    int          errors = 0;
    imm_extend_if b0 ();
    imm_extend_if b1 ();
    assign b0.Start = start;
    assign b0.Instr = instr;
    assign b0.ImmSrc = src;
    assign b1.Start = start;
    assign b1.Instr = instr;
    assign b1.ImmSrc = src;
    imm_extend_unit #(.FAST_ROT(0), .ILLEGAL_ZERO(1)) u0 (.clk(clk), .reset(reset), .bus(b0));
    imm_extend_unit #(.FAST_ROT(1), .ILLEGAL_ZERO(0)) u1 (.clk(clk), .reset(reset), .bus(b1));
    always #5 clk = ~clk;
    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask
    task automatic run(input string tag, input logic [23:0] ins, input logic [2:0] s,
                       input logic [31:0] e0, input logic [31:0] e1,
                       input logic ec, input logic ecv, input logic eill,
                       input int l0, input int l1);
        int lat0 = 0, lat1 = 0, busy = 0;
        logic [31:0] x0 = '0, x1 = '0;
        logic c0 = 0, v0 = 0, i0 = 0, c1 = 0, v1 = 0, i1 = 0;
        @(negedge clk);
        instr = ins;
        src = s;
        start = 1'b1;
        for (int k = 1; k <= 20; k++) begin
            @(negedge clk);
            start = 1'b0;
            instr = ~ins;
            src = 3'd2;
            busy += int'(b0.Busy);
            if (b0.Done && lat0 == 0) begin
                lat0 = k; x0 = b0.ExtImm; c0 = b0.ImmCarry; v0 = b0.ImmCarryValid; i0 = b0.IllegalSrc;
            end
            if (b1.Done && lat1 == 0) begin
                lat1 = k; x1 = b1.ExtImm; c1 = b1.ImmCarry; v1 = b1.ImmCarryValid; i1 = b1.IllegalSrc;
            end
            if (lat0 != 0 && lat1 != 0) break;
        end
        chk({tag, " lat0"}, lat0, l0);
        chk({tag, " lat1"}, lat1, l1);
        chk({tag, " busy0"}, busy, l0 - 1);
        chk({tag, " ext0"}, x0, e0);
        chk({tag, " ext1"}, x1, e1);
        chk({tag, " flags0"}, {c0, v0, i0}, {ec, ecv, eill});
        chk({tag, " flags1"}, {c1, v1, i1}, {ec, ecv, eill});
        @(negedge clk);
        chk({tag, " done_pulse"}, {b0.Done, b1.Done}, 2'b00);
        chk({tag, " hold0"}, b0.ExtImm, e0);
    endtask
    initial begin
        int lat;
        #12;
        chk("rst_outs0", {b0.Busy, b0.Done, b0.ImmCarry, b0.ImmCarryValid, b0.IllegalSrc}, 5'b0);
        chk("rst_ext0", b0.ExtImm, 32'h0);
        chk("rst_outs1", {b1.Busy, b1.Done, b1.ImmCarry, b1.ImmCarryValid, b1.IllegalSrc, b1.ExtImm}, 37'b0);
        @(negedge clk);
        reset = 1'b0;
        run("dp_4ff",  24'h0004FF, 3'd0, 32'hFF000000, 32'hFF000000, 1, 1, 0, 5, 1);
        run("dp_f01",  24'h000F01, 3'd0, 32'h00000004, 32'h00000004, 0, 1, 0, 16, 1);
        run("dp_zero", 24'h000300, 3'd0, 32'h0, 32'h0, 0, 1, 0, 4, 1);
        run("dp_rot0", 24'h000081, 3'd0, 32'h00000081, 32'h00000081, 0, 0, 0, 1, 1);
        run("plain",   24'h000080, 3'd4, 32'h00000080, 32'h00000080, 0, 0, 0, 1, 1);
        run("branch",  24'hFFFFFE, 3'd2, 32'hFFFFFFF8, 32'hFFFFFFF8, 0, 0, 0, 1, 1);
        run("ldr",     24'h000ABC, 3'd1, 32'h00000ABC, 32'h00000ABC, 0, 0, 0, 1, 1);
        run("ldrh",    24'h000A05, 3'd3, 32'h000000A5, 32'h000000A5, 0, 0, 0, 1, 1);
        run("br_pos",  24'h00048D, 3'd2, 32'h00001234, 32'h00001234, 0, 0, 0, 1, 1);
        run("illegal", 24'h0004FF, 3'd7, 32'h0, 32'h00001234, 0, 0, 1, 1, 1);
        run("ill_101", 24'h0004FF, 3'd5, 32'h0, 32'h00001234, 0, 0, 1, 1, 1);
        // Start pulsed while u0 is busy must be ignored
        lat = 0;
        @(negedge clk);
        instr = 24'h0008AB;
        src = 3'd0;
        start = 1'b1;
        for (int k = 1; k <= 20; k++) begin
            @(negedge clk);
            start = (k == 2);
            if (k == 2) begin
                instr = 24'h000000;
                src = 3'd1;
            end
            if (b0.Done && lat == 0) begin
                lat = k;
                chk("ignore ext", b0.ExtImm, 32'h00AB0000);
                chk("ignore flags", {b0.ImmCarry, b0.ImmCarryValid, b0.IllegalSrc}, 3'b010);
            end
            if (lat != 0) break;
        end
        chk("ignore lat", lat, 9);
        // Back-to-back: new Start held through the Done cycle
        @(negedge clk);
        instr = 24'h000ABC;
        src = 3'd1;
        start = 1'b1;
        @(negedge clk);
        chk("b2b first", {31'b0, b0.Done}, 1);
        chk("b2b ext", b0.ExtImm, 32'h00000ABC);
        instr = 24'h0004FF;
        src = 3'd0;
        lat = 0;
        for (int k = 1; k <= 20; k++) begin
            @(negedge clk);
            start = 1'b0;
            if (k == 1) chk("b2b fast", {b1.Done, b1.ExtImm}, {1'b1, 32'hFF000000});
            if (b0.Done && lat == 0) begin
                lat = k;
                chk("b2b second", b0.ExtImm, 32'hFF000000);
            end
            if (lat != 0) break;
        end
        chk("b2b lat", lat, 5);
        // Asynchronous reset mid-rotation
        @(negedge clk);
        instr = 24'h0008AB;
        src = 3'd0;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        @(negedge clk);
        chk("pre_rst busy", {31'b0, b0.Busy}, 1);
        #2 reset = 1'b1;
        #1;
        chk("async rst0", {b0.Busy, b0.Done, b0.ImmCarry, b0.ImmCarryValid, b0.IllegalSrc}, 5'b0);
        chk("async ext0", b0.ExtImm, 32'h0);
        chk("async ext1", b1.ExtImm, 32'h0);
        @(negedge clk);
        reset = 1'b0;
        run("post_rst", 24'h0004FF, 3'd0, 32'hFF000000, 32'hFF000000, 1, 1, 0, 5, 1);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
